uart_rx: RTL and testbench



---
 rtl/uart_rx.sv | 118 +++++++++++
 tb/tb_uart_rx.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver (8 data LSB first, parity, 1 stop).
// Ports: clk, rst (async high), clk_bd (16x tick), rx -> dataout, rdsig,
//        dataerror, frameerror, busy.
module uart_rx #(
  parameter logic PARITYMODE = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_bd,
  input  logic       rx,
  output logic [7:0] dataout,
  output logic       rdsig,
  output logic       dataerror,
  output logic       frameerror,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t      state;
  logic        rx_m;
  logic        rx_s;
  logic        rx_d;
  logic [3:0]  tcnt;
  logic [2:0]  bcnt;
  logic [7:0]  shift;
  logic        s7;
  logic        s8;
  logic        par;
  logic        fall;
  logic        maj;
  logic        mid;
  logic        last;

  assign fall = rx_d & ~rx_s;
  // Majority of the tcnt=7/8 samples and the live tcnt=9 value.
  assign maj  = (s7 & s8) | (s7 & rx_s) | (s8 & rx_s);
  assign mid  = clk_bd && (tcnt == 4'd9);
  assign last = clk_bd && (tcnt == 4'd15);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rx_m       <= 1'b1;
      rx_s       <= 1'b1;
      rx_d       <= 1'b1;
      tcnt       <= 4'd0;
      bcnt       <= 3'd0;
      shift      <= 8'd0;
      s7         <= 1'b0;
      s8         <= 1'b0;
      par        <= 1'b0;
      dataout    <= 8'd0;
      rdsig      <= 1'b0;
      dataerror  <= 1'b0;
      frameerror <= 1'b0;
      busy       <= 1'b0;
    end else begin
      rx_m  <= rx;
      rx_s  <= rx_m;
      rx_d  <= rx_s;
      rdsig <= 1'b0;
      if (state != IDLE && clk_bd) begin
        tcnt <= tcnt + 4'd1;
        if (tcnt == 4'd7) s7 <= rx_s;
        if (tcnt == 4'd8) s8 <= rx_s;
      end
      unique case (state)
        IDLE: begin
          if (fall) begin
            state <= START;
            tcnt  <= 4'd0;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (mid && maj) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (last) begin
            state <= DATA;
            bcnt  <= 3'd0;
          end
        end
        DATA: begin
          if (mid) shift <= {maj, shift[7:1]};
          if (last) begin
            bcnt <= bcnt + 3'd1;
            if (bcnt == 3'd7) state <= PARITY;
          end
        end
        PARITY: begin
          if (mid) par <= maj;
          if (last) state <= STOP;
        end
        STOP: begin
          // Leave at mid-stop-bit so the next start edge is never missed.
          if (mid) begin
            dataout    <= shift;
            dataerror  <= par != (PARITYMODE ^ (^shift));
            frameerror <= ~maj;
            rdsig      <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized + directed frames checked against a frame-level model.
// Drives rx per 16x tick; captures every rdsig pulse in a monitor queue.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clk_bd = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] dataout;
  logic       rdsig;
  logic       dataerror;
  logic       frameerror;
  logic       busy;

  uart_rx #(.PARITYMODE(1'b0)) dut (
    .clk(clk),
    .rst(rst),
    .clk_bd(clk_bd),
    .rx(rx),
    .dataout(dataout),
    .rdsig(rdsig),
    .dataerror(dataerror),
    .frameerror(frameerror),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int div = 0;
  bit bd_high = 1'b0;
  always @(negedge clk) begin
    div = (div + 1) % 4;
    clk_bd = bd_high || (div == 0);
  end

  int unsigned ticks = 0;
  always @(posedge clk) if (clk_bd) ticks <= ticks + 1;

  typedef struct {
    logic [7:0] d;
    logic       de;
    logic       fe;
    logic       b;
    int         lat;
  } ev_t;

  ev_t         evq[$];
  int unsigned start_tick = 0;
  logic        prev_rd = 1'b0;
  int          dbl = 0;

  always @(negedge clk) begin
    if (rdsig) begin
      ev_t e;
      e.d   = dataout;
      e.de  = dataerror;
      e.fe  = frameerror;
      e.b   = busy;
      e.lat = int'(ticks - start_tick);
      evq.push_back(e);
    end
    if (rdsig && prev_rd) dbl++;
    prev_rd = rdsig;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic v);
    rx = v;
    do @(posedge clk); while (!clk_bd);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b1);
  endtask

  task automatic sync_tick();
    do @(posedge clk); while (!clk_bd);
    @(negedge clk);
    start_tick = ticks;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic p,
                            input logic stp, input int gbit);
    logic [10:0] bits;
    logic        v;
    bits = {stp, p, b, 1'b0};
    sync_tick();
    for (int k = 0; k < 11; k++) begin
      for (int t = 1; t <= 16; t++) begin
        v = bits[k];
        if (k == gbit && t == 9) v = ~v;
        tick(v);
      end
    end
  endtask

  // Frame-level reference: even parity over the byte, stop must be 1.
  task automatic check_ev(input string tag, input logic [7:0] b,
                          input logic p, input logic stp, input int lat);
    ev_t e;
    chk({tag, " present"}, evq.size() > 0, 1);
    if (evq.size() > 0) begin
      e = evq.pop_front();
      chk({tag, " data"}, e.d, b);
      chk({tag, " dataerror"}, e.de, p != (^b));
      chk({tag, " frameerror"}, e.fe, !stp);
      chk({tag, " busy"}, e.b, 0);
      chk({tag, " latency"}, e.lat, lat);
    end
  endtask

  initial begin
    logic [7:0] b;
    logic       p;
    logic       s;
    logic [7:0] held;

    repeat (3) @(negedge clk);
    chk("reset dataout", dataout, 0);
    chk("reset rdsig", rdsig, 0);
    chk("reset dataerror", dataerror, 0);
    chk("reset frameerror", frameerror, 0);
    chk("reset busy", busy, 0);
    rst = 1'b0;
    idle(5);

    send_frame(8'h55, 1'b0, 1'b1, -1);
    idle(4);
    check_ev("clean55", 8'h55, 1'b0, 1'b1, 170);

    send_frame(8'hA7, 1'b0, 1'b1, -1);
    idle(4);
    check_ev("badparA7", 8'hA7, 1'b0, 1'b1, 170);
    send_frame(8'hA7, 1'b1, 1'b1, -1);
    idle(4);
    check_ev("goodparA7", 8'hA7, 1'b1, 1'b1, 170);

    send_frame(8'h3C, 1'b0, 1'b0, -1);
    idle(4);
    check_ev("stoplow3C", 8'h3C, 1'b0, 1'b0, 170);
    send_frame(8'h81, 1'b0, 1'b1, -1);
    idle(4);
    check_ev("after81", 8'h81, 1'b0, 1'b1, 170);

    held = dataout;
    sync_tick();
    repeat (4) tick(1'b0);
    chk("false start busy high", busy, 1);
    repeat (8) tick(1'b1);
    chk("false start busy low", busy, 0);
    chk("false start no rdsig", evq.size(), 0);
    chk("false start data held", dataout, held);
    idle(4);

    send_frame(8'hF0, 1'b0, 1'b1, 3);
    idle(4);
    check_ev("glitchF0", 8'hF0, 1'b0, 1'b1, 170);

    send_frame(8'h00, 1'b0, 1'b1, -1);
    send_frame(8'hFF, 1'b0, 1'b1, -1);
    idle(4);
    chk("b2b count", evq.size(), 2);
    check_ev("b2b00", 8'h00, 1'b0, 1'b1, 170);
    check_ev("b2bFF", 8'hFF, 1'b0, 1'b1, 170);

    sync_tick();
    repeat (11 * 16) tick(1'b0);
    repeat (40) tick(1'b0);
    chk("break count", evq.size(), 1);
    check_ev("break", 8'h00, 1'b0, 1'b0, 170);
    idle(8);
    chk("break release quiet", evq.size(), 0);

    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom);
      p = (^b) ^ ($urandom_range(0, 3) == 0);
      s = ($urandom_range(0, 3) != 0);
      send_frame(b, p, s, -1);
      idle(4);
      check_ev($sformatf("rand%0d", i), b, p, s, 170);
    end

    bd_high = 1'b1;
    idle(4);
    b = 8'($urandom);
    send_frame(b, ^b, 1'b1, -1);
    idle(4);
    check_ev("bdhigh", b, ^b, 1'b1, 173);
    bd_high = 1'b0;
    idle(4);

    send_frame(8'h5A, 1'b1, 1'b0, -1);
    idle(4);
    check_ev("pre-reset5A", 8'h5A, 1'b1, 1'b0, 170);
    sync_tick();
    b = 8'h81;
    repeat (16) tick(1'b0);
    for (int k = 0; k < 3; k++) repeat (16) tick(b[k]);
    repeat (8) tick(b[3]);
    rst = 1'b1;
    #1;
    chk("midrst dataout", dataout, 0);
    chk("midrst rdsig", rdsig, 0);
    chk("midrst dataerror", dataerror, 0);
    chk("midrst frameerror", frameerror, 0);
    chk("midrst busy", busy, 0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(20);
    chk("midrst no rdsig", evq.size(), 0);
    send_frame(8'h81, 1'b0, 1'b1, -1);
    idle(4);
    check_ev("postrst81", 8'h81, 1'b0, 1'b1, 170);

    chk("rdsig single cycle", dbl, 0);
    chk("no stray events", evq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
